// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the fetch program-counter unit.
//   pc_state_t           : BOOT (first cycle after reset), RUN (normal fetch),
//                          HOLD (stalled while a redirect is buffered)
//   DEFAULT_RESET_VECTOR : PC value held during reset and fetched first
//   INSTR_BYTES          : byte distance between sequential fetches
//   is_word_aligned()    : true when the low address bits select a word start
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES          = 32'd4;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational priority mux that chooses the next fetch PC, the next control
// state and the next contents of the buffered-redirect register.
//
// Optional build macro: PC_MISALIGN_TRAP_EN
//   defined   : misaligned redirect targets are refused and flagged on
//               misalign_o; the PC holds.
//   undefined : redirect targets are loaded with bits [1:0] cleared.
//
// Ports
//   state_i, stall_i                 current state and hazard stall
//   redirect_valid_i/redirect_addr_i taken branch/jump from EX
//   trap_valid_i/trap_vec_i          trap request and handler address
//   fetch_valid_i/fetch_ready_i      current IF handshake
//   pc_i, pc_seq_i                   current PC and PC+INCR
//   pend_valid_i/pend_addr_i         buffered redirect register contents
//   pc_d_o, state_d_o                next PC and next state
//   pend_valid_d_o/pend_addr_d_o     next buffered-redirect contents
//   misalign_o                       (macro only) refused misaligned target
// -----------------------------------------------------------------------------
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  pc_state_t         state_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_addr_i,
    input  logic              trap_valid_i,
    input  logic [XLEN-1:0]   trap_vec_i,
    input  logic              fetch_valid_i,
    input  logic              fetch_ready_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   pc_seq_i,
    input  logic              pend_valid_i,
    input  logic [XLEN-1:0]   pend_addr_i,
    output logic [XLEN-1:0]   pc_d_o,
    output pc_state_t         state_d_o,
    output logic              pend_valid_d_o,
    output logic [XLEN-1:0]   pend_addr_d_o
`ifdef PC_MISALIGN_TRAP_EN
   ,output logic              misalign_o
`endif
);

    logic [XLEN-1:0] target_s;
    logic            bad_target_s;

`ifdef PC_MISALIGN_TRAP_EN
    assign target_s     = redirect_addr_i;
    assign bad_target_s = redirect_valid_i && !is_word_aligned(redirect_addr_i[1:0]);
    // Only flag a refused target when the redirect would actually be considered.
    assign misalign_o   = bad_target_s && (state_i != BOOT) && !trap_valid_i;
`else
    // Instructions are word aligned, so the low address bits are dropped.
    assign target_s     = redirect_addr_i & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign bad_target_s = 1'b0;
`endif

    // Priority selection of next PC, next state and buffered redirect.
    always_comb begin
        pc_d_o         = pc_i;
        state_d_o      = state_i;
        pend_valid_d_o = pend_valid_i;
        pend_addr_d_o  = pend_addr_i;
        case (state_i)
            BOOT: begin
                // Redirects are ignored before the first fetch; a trap is not.
                if (trap_valid_i) begin
                    pc_d_o = trap_vec_i;
                end else begin
                    pc_d_o = pc_i;
                end
                pend_valid_d_o = 1'b0;
                state_d_o      = RUN;
            end
            RUN, HOLD: begin
                if (trap_valid_i) begin
                    pc_d_o         = trap_vec_i;
                    pend_valid_d_o = 1'b0;
                    state_d_o      = RUN;
                end else if (bad_target_s) begin
                    // Refused target: everything holds while the trap follows.
                    pc_d_o = pc_i;
                end else if (redirect_valid_i && !stall_i) begin
                    // A fresh redirect supersedes any older buffered one.
                    pc_d_o         = target_s;
                    pend_valid_d_o = 1'b0;
                    state_d_o      = RUN;
                end else if (redirect_valid_i) begin
                    // Stalled: remember the youngest target until the stall lifts.
                    pend_addr_d_o  = target_s;
                    pend_valid_d_o = 1'b1;
                    state_d_o      = HOLD;
                end else if ((state_i == HOLD) && !stall_i) begin
                    pc_d_o         = pend_addr_i;
                    pend_valid_d_o = 1'b0;
                    state_d_o      = RUN;
                end else if (stall_i) begin
                    pc_d_o = pc_i;
                end else if (fetch_valid_i && fetch_ready_i) begin
                    pc_d_o = pc_seq_i;
                end else begin
                    // Back-pressure: keep the outstanding request stable.
                    pc_d_o = pc_i;
                end
            end
            default: begin
                pc_d_o         = pc_i;
                pend_valid_d_o = 1'b0;
                state_d_o      = BOOT;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter unit at the front of the IF stage. Holds the fetch PC,
// presents a valid/ready request to instruction memory, and picks the next PC
// from sequential increment, branch/jump redirect or trap vector. A redirect
// arriving during a hazard stall is buffered and applied when the stall lifts.
//
// Optional build macro: PC_MISALIGN_TRAP_EN (adds MISALIGN output; refuses
// misaligned redirect targets instead of clearing their low bits).
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   STALL                hazard freeze; also forces FETCH_VALID low
//   REDIRECT_VALID/ADDR  taken branch/jump target
//   TRAP_VALID/TRAP_VEC  trap request and handler address
//   FETCH_READY          instruction memory accepts the request
//   FETCH_VALID          PC_OUT is a valid fetch request
//   PC_OUT               current fetch PC
//   PC_NEXT_SEQ          PC_OUT + INCR (modulo 2^XLEN), for the link register
//   REDIRECT_PENDING     a buffered redirect is waiting
//   MISALIGN             (macro only) one-cycle pulse on a refused target
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int unsigned      INCR         = INSTR_BYTES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              REDIRECT_VALID,
    input  logic [XLEN-1:0]   REDIRECT_ADDR,
    input  logic              TRAP_VALID,
    input  logic [XLEN-1:0]   TRAP_VEC,
    input  logic              FETCH_READY,
    output logic              FETCH_VALID,
    output logic [XLEN-1:0]   PC_OUT,
    output logic [XLEN-1:0]   PC_NEXT_SEQ,
    output logic              REDIRECT_PENDING
`ifdef PC_MISALIGN_TRAP_EN
   ,output logic              MISALIGN
`endif
);

    pc_state_t       state_q;
    pc_state_t       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_seq_s;
    logic            pend_valid_q;
    logic            pend_valid_d;
    logic [XLEN-1:0] pend_addr_q;
    logic [XLEN-1:0] pend_addr_d;
    logic            fetch_valid_s;

    // Natural wrap of the adder gives the modulo-2^XLEN behaviour.
    assign pc_seq_s = pc_q + XLEN'(INCR);

    // A request is offered only in RUN; HOLD is a redirect bubble and BOOT
    // is the one-cycle gap after reset.
    assign fetch_valid_s = (state_q == RUN) && !STALL;

    assign FETCH_VALID      = fetch_valid_s;
    assign PC_OUT           = pc_q;
    assign PC_NEXT_SEQ      = pc_seq_s;
    assign REDIRECT_PENDING = pend_valid_q;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_s;
    logic misalign_q;
`endif

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_next_sel (
        .state_i          (state_q),
        .stall_i          (STALL),
        .redirect_valid_i (REDIRECT_VALID),
        .redirect_addr_i  (REDIRECT_ADDR),
        .trap_valid_i     (TRAP_VALID),
        .trap_vec_i       (TRAP_VEC),
        .fetch_valid_i    (fetch_valid_s),
        .fetch_ready_i    (FETCH_READY),
        .pc_i             (pc_q),
        .pc_seq_i         (pc_seq_s),
        .pend_valid_i     (pend_valid_q),
        .pend_addr_i      (pend_addr_q),
        .pc_d_o           (pc_d),
        .state_d_o        (state_d),
        .pend_valid_d_o   (pend_valid_d),
        .pend_addr_d_o    (pend_addr_d)
`ifdef PC_MISALIGN_TRAP_EN
       ,.misalign_o       (misalign_s)
`endif
    );

    // PC, state and buffered-redirect registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q         <= RESET_VECTOR;
            state_q      <= BOOT;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= {XLEN{1'b0}};
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Registered one-cycle misalignment pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_s;
        end
    end

    assign MISALIGN = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0;
    logic        REDIRECT_VALID = 1'b0;
    logic [31:0] REDIRECT_ADDR = 32'h0;
    logic        TRAP_VALID = 1'b0;
    logic [31:0] TRAP_VEC = 32'h0;
    logic        FETCH_READY = 1'b0;
    logic        FETCH_VALID;
    logic [31:0] PC_OUT;
    logic [31:0] PC_NEXT_SEQ;
    logic        REDIRECT_PENDING;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural PC, "first cycle after reset" flag,
    // and an optional waiting redirect target.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_paddr;

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INCR         (4)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .STALL            (STALL),
        .REDIRECT_VALID   (REDIRECT_VALID),
        .REDIRECT_ADDR    (REDIRECT_ADDR),
        .TRAP_VALID       (TRAP_VALID),
        .TRAP_VEC         (TRAP_VEC),
        .FETCH_READY      (FETCH_READY),
        .FETCH_VALID      (FETCH_VALID),
        .PC_OUT           (PC_OUT),
        .PC_NEXT_SEQ      (PC_NEXT_SEQ),
        .REDIRECT_PENDING (REDIRECT_PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_boot  = 1'b1;
        m_pend  = 1'b0;
        m_paddr = 32'h0000_0000;
    endtask

    // One rising edge of the architectural rules, from the inputs held across it.
    task automatic model_edge();
        if (m_boot) begin
            if (TRAP_VALID) m_pc = TRAP_VEC;
            m_boot = 1'b0;
        end else if (TRAP_VALID) begin
            m_pc   = TRAP_VEC;
            m_pend = 1'b0;
        end else if (REDIRECT_VALID && !STALL) begin
            m_pc   = REDIRECT_ADDR & 32'hFFFF_FFFC;
            m_pend = 1'b0;
        end else if (REDIRECT_VALID) begin
            m_paddr = REDIRECT_ADDR & 32'hFFFF_FFFC;
            m_pend  = 1'b1;
        end else if (m_pend) begin
            if (!STALL) begin
                m_pc   = m_paddr;
                m_pend = 1'b0;
            end
        end else if (!STALL && FETCH_READY) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        chk("fetch_valid", {31'b0, FETCH_VALID}, {31'b0, (!m_boot && !m_pend && !STALL)});
        chk("pc_out", PC_OUT, m_pc);
        chk("pc_next_seq", PC_NEXT_SEQ, m_pc + 32'd4);
        chk("redirect_pending", {31'b0, REDIRECT_PENDING}, {31'b0, m_pend});
    endtask

    // Advance one clock: model follows the edge, outputs compared on the
    // falling edge, then control returns 1ns later for new stimulus.
    task automatic step();
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        @(negedge CLK);
        compare_all();
        #1;
    endtask

    task automatic drive(input bit s, input bit rv, input logic [31:0] ra,
                         input bit t, input logic [31:0] tv, input bit rdy);
        STALL          = s;
        REDIRECT_VALID = rv;
        REDIRECT_ADDR  = ra;
        TRAP_VALID     = t;
        TRAP_VEC       = tv;
        FETCH_READY    = rdy;
    endtask

    initial begin
        model_reset();
        // Long power-on reset.
        repeat (2000) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pc", PC_OUT, 32'h0);
        chk("rst_fv", {31'b0, FETCH_VALID}, 32'h0);
        chk("rst_pend", {31'b0, REDIRECT_PENDING}, 32'h0);
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        RST = 1'b0;
        chk("boot_fv_low", {31'b0, FETCH_VALID}, 32'h0);
        step(); chk("run_pc0", PC_OUT, 32'h0); chk("run_fv", {31'b0, FETCH_VALID}, 32'h1);
        step(); chk("run_pc4", PC_OUT, 32'h4);
        step(); chk("run_pc8", PC_OUT, 32'h8);

        // Back-pressure at a trap-loaded PC.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_016a, 1'b0);
        step(); chk("trap_16a", PC_OUT, 32'h16a);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_pc", PC_OUT, 32'h16a);
            chk("bp_fv", {31'b0, FETCH_VALID}, 32'h1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(); chk("bp_release", PC_OUT, 32'h16e);

        // Stalled redirect is buffered, then applied when the stall drops.
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
        step(); chk("stall_pc", PC_OUT, 32'h16e); chk("stall_pend", {31'b0, REDIRECT_PENDING}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(); chk("stall_hold_pc", PC_OUT, 32'h16e);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(); chk("pend_apply", PC_OUT, 32'h200); chk("pend_clr", {31'b0, REDIRECT_PENDING}, 32'h0);

        // Trap beats a simultaneous redirect and stall, and clears the buffer.
        drive(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b1);
        step(); chk("pre_trap_pend", {31'b0, REDIRECT_PENDING}, 32'h1);
        drive(1'b1, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0080, 1'b1);
        step(); chk("trap_pc", PC_OUT, 32'h80); chk("trap_pend", {31'b0, REDIRECT_PENDING}, 32'h0);

        // Wrap-around of the sequential increment.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(); chk("wrap_pc", PC_OUT, 32'hFFFF_FFFC); chk("wrap_seq", PC_NEXT_SEQ, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(); chk("wrap_zero", PC_OUT, 32'h0);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] ra;
            logic [31:0] tv;
            ra = $urandom;
            tv = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ra,
                  ($urandom_range(0, 15) == 0), tv, ($urandom_range(0, 1) == 1));
            step();
        end

        // Asynchronous reset in the middle of a cycle.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_010f, 1'b1);
        step(); chk("pre_rst_pc", PC_OUT, 32'h10f);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_pc", PC_OUT, 32'h0);
        chk("async_rst_fv", {31'b0, FETCH_VALID}, 32'h0);
        model_reset();
        step();
        step();
        RST = 1'b0;
        chk("reboot_fv_low", {31'b0, FETCH_VALID}, 32'h0);
        step(); chk("reboot_pc0", PC_OUT, 32'h0);
        step(); chk("reboot_pc4", PC_OUT, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
